id_ex_stage: RTL and testbench

//  ID/EX pipeline register and operand-delivery stage feeding the ALU.
//  - Captures decoded operands and control from decode over a valid/ready handshake.
//  - Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
//  - Detects load-use hazards and stalls decode by one cycle.
//  - Drives the ALU operands a, b and ALUControl, plus the store data and control for downstream stages.

---
 rtl/ex_stage_pkg.sv | 29 ++
 rtl/id_ex_stage_if.sv | 32 +++
 rtl/id_ex_stage_forward_mux.sv | 38 +++
 rtl/id_ex_stage.sv | 135 +++++++++++++
 tb/tb_id_ex_stage.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_stage_pkg: shared control struct, zero register, ALU opcodes  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package ex_stage_pkg;

    localparam int unsigned XZR = 31;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [3:0] ALU_LSL  = 4'b1000;
    localparam logic [3:0] ALU_LSR  = 4'b1001;

    typedef struct packed {
        logic       alusrc;
        logic [3:0] alucontrol;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_ex_stage_if: decode-to-EX valid/ready operand bus             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface id_ex_stage_if #(
    parameter int N      = 64,
    parameter int REG_AW = 5
);
    import ex_stage_pkg::*;

    logic              id_valid;
    logic              id_ready;
    logic [N-1:0]      id_rd1;
    logic [N-1:0]      id_rd2;
    logic [N-1:0]      id_imm;
    logic [REG_AW-1:0] id_rn;
    logic [REG_AW-1:0] id_rm;
    logic [REG_AW-1:0] id_rd;
    ctrl_t             id_ctrl;

    modport master (
        output id_valid, id_rd1, id_rd2, id_imm, id_rn, id_rm, id_rd, id_ctrl,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_rd1, id_rd2, id_imm, id_rn, id_rm, id_rd, id_ctrl,
        output id_ready
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_forward_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | forward_mux: per-operand EX/MEM > MEM/WB > regfile source select |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module forward_mux
    import ex_stage_pkg::*;
#(
    parameter int N      = 64,
    parameter int REG_AW = 5
) (
    input  wire logic [REG_AW-1:0] src,
    input  wire logic [N-1:0]      reg_val,
    input  wire logic              exmem_regwrite,
    input  wire logic [REG_AW-1:0] exmem_rd,
    input  wire logic [N-1:0]      exmem_result,
    input  wire logic              memwb_regwrite,
    input  wire logic [REG_AW-1:0] memwb_rd,
    input  wire logic [N-1:0]      memwb_result,
    output logic      [N-1:0]      fwd
);
    localparam logic [REG_AW-1:0] ZR = REG_AW'(XZR);

    logic w_src_live;

    assign w_src_live = (src != ZR);

    // EX/MEM is the younger producer, so it is checked first
    always_comb begin
        fwd = reg_val;
        if (w_src_live && exmem_regwrite && (exmem_rd == src)) begin
            fwd = exmem_result;
        end else if (w_src_live && memwb_regwrite && (memwb_rd == src)) begin
            fwd = memwb_result;
        end
    end
endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_ex_stage: ID/EX register with forwarding and load-use stall   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module id_ex_stage
    import ex_stage_pkg::*;
#(
    parameter int N      = 64,
    parameter int REG_AW = 5
) (
    input  wire logic              clk,
    input  wire logic              reset,
    id_ex_stage_if.slave           id_bus,
    input  wire logic              flush,
    input  wire logic              exmem_regwrite,
    input  wire logic [REG_AW-1:0] exmem_rd,
    input  wire logic [N-1:0]      exmem_result,
    input  wire logic              memwb_regwrite,
    input  wire logic [REG_AW-1:0] memwb_rd,
    input  wire logic [N-1:0]      memwb_result,
    output logic                   ex_valid,
    output logic      [N-1:0]      alu_a,
    output logic      [N-1:0]      alu_b,
    output logic      [3:0]        alu_control,
    output logic      [N-1:0]      ex_store_data,
    output logic      [REG_AW-1:0] ex_rd,
    output ctrl_t                  ex_ctrl
);
    localparam logic [REG_AW-1:0] ZR = REG_AW'(XZR);

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q,  ctrl_d;
    logic [N-1:0]      rd1_q,   rd1_d;
    logic [N-1:0]      rd2_q,   rd2_d;
    logic [N-1:0]      imm_q,   imm_d;
    logic [REG_AW-1:0] rn_q,    rn_d;
    logic [REG_AW-1:0] rm_q,    rm_d;
    logic [REG_AW-1:0] rd_q,    rd_d;

    logic              stall;
    logic [N-1:0]      fwd_a;
    logic [N-1:0]      fwd_b;

    // rm only matters when it is really read as a register (not an immediate op) or is store data
    assign stall = valid_q && ctrl_q.memread && (rd_q != ZR) && id_bus.id_valid &&
                   ((rd_q == id_bus.id_rn) ||
                    ((rd_q == id_bus.id_rm) && (!id_bus.id_ctrl.alusrc || id_bus.id_ctrl.memwrite)));

    assign id_bus.id_ready = !stall;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        rd_d    = rd_q;
        if (!flush && id_bus.id_valid && !stall) begin
            valid_d = 1'b1;
            ctrl_d  = id_bus.id_ctrl;
            rd1_d   = id_bus.id_rd1;
            rd2_d   = id_bus.id_rd2;
            imm_d   = id_bus.id_imm;
            rn_d    = id_bus.id_rn;
            rm_d    = id_bus.id_rm;
            rd_d    = id_bus.id_rd;
        end else begin
            // Bubble: kill side effects, keep data fields as they were
            valid_d           = 1'b0;
            ctrl_d.regwrite   = 1'b0;
            ctrl_d.memread    = 1'b0;
            ctrl_d.memwrite   = 1'b0;
            ctrl_d.branch     = 1'b0;
            ctrl_d.alucontrol = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            rd_q    <= rd_d;
        end
    end

    forward_mux #(.N(N), .REG_AW(REG_AW)) u_fwd_a (
        .src            (rn_q),
        .reg_val        (rd1_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .fwd            (fwd_a)
    );

    forward_mux #(.N(N), .REG_AW(REG_AW)) u_fwd_b (
        .src            (rm_q),
        .reg_val        (rd2_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .fwd            (fwd_b)
    );

    assign ex_valid      = valid_q;
    assign ex_ctrl       = ctrl_q;
    assign ex_rd         = rd_q;
    assign alu_control   = ctrl_q.alucontrol;
    assign alu_a         = fwd_a;
    assign ex_store_data = fwd_b;
    assign alu_b         = ctrl_q.alusrc ? imm_q : fwd_b;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_id_ex_stage: directed + random vectors against a stage model  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_id_ex_stage;
    import ex_stage_pkg::*;

    localparam int N      = 64;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush;
    logic              exmem_regwrite;
    logic [REG_AW-1:0] exmem_rd;
    logic [N-1:0]      exmem_result;
    logic              memwb_regwrite;
    logic [REG_AW-1:0] memwb_rd;
    logic [N-1:0]      memwb_result;
    logic              ex_valid;
    logic [N-1:0]      alu_a, alu_b, ex_store_data;
    logic [3:0]        alu_control;
    logic [REG_AW-1:0] ex_rd;
    ctrl_t             ex_ctrl;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    id_ex_stage_if #(.N(N), .REG_AW(REG_AW)) id_bus ();

    id_ex_stage #(.N(N), .REG_AW(REG_AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_bus         (id_bus),
        .flush          (flush),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .ex_valid       (ex_valid),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_control    (alu_control),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_ctrl        (ex_ctrl)
    );

    always #5 clk = ~clk;

    // Model: what instruction sits in EX, as a plain record
    logic              m_valid;
    ctrl_t             m_ctrl;
    logic [N-1:0]      m_rd1, m_rd2, m_imm;
    logic [REG_AW-1:0] m_rn, m_rm, m_rd;

    function automatic logic m_stall();
        logic uses_rm;
        uses_rm = !id_bus.id_ctrl.alusrc || id_bus.id_ctrl.memwrite;
        return m_valid && m_ctrl.memread && (m_rd != 5'd31) && id_bus.id_valid &&
               ((m_rd == id_bus.id_rn) || ((m_rd == id_bus.id_rm) && uses_rm));
    endfunction

    function automatic logic [N-1:0] m_src(input logic [REG_AW-1:0] r, input logic [N-1:0] v);
        if (r == 5'd31) return v;
        if (exmem_regwrite && exmem_rd == r) return exmem_result;
        if (memwb_regwrite && memwb_rd == r) return memwb_result;
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0; m_ctrl <= '0; m_rd1 <= '0; m_rd2 <= '0; m_imm <= '0;
            m_rn <= '0; m_rm <= '0; m_rd <= '0;
        end else if (!flush && id_bus.id_valid && !m_stall()) begin
            m_valid <= 1'b1; m_ctrl <= id_bus.id_ctrl;
            m_rd1 <= id_bus.id_rd1; m_rd2 <= id_bus.id_rd2; m_imm <= id_bus.id_imm;
            m_rn <= id_bus.id_rn; m_rm <= id_bus.id_rm; m_rd <= id_bus.id_rd;
        end else begin
            m_valid <= 1'b0;
            m_ctrl.regwrite <= 1'b0; m_ctrl.memread <= 1'b0;
            m_ctrl.memwrite <= 1'b0; m_ctrl.branch  <= 1'b0;
            m_ctrl.alucontrol <= 4'b0000;
        end
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ex_valid",    N'(ex_valid), N'(m_valid));
            check("ex_ctrl",     N'(ex_ctrl), N'(m_ctrl));
            check("ex_rd",       N'(ex_rd), N'(m_rd));
            check("alu_control", N'(alu_control), N'(m_ctrl.alucontrol));
            check("alu_a",       alu_a, m_src(m_rn, m_rd1));
            check("alu_b",       alu_b, m_ctrl.alusrc ? m_imm : m_src(m_rm, m_rd2));
            check("store_data",  ex_store_data, m_src(m_rm, m_rd2));
            check("id_ready",    N'(id_bus.id_ready), N'(!m_stall()));
        end
    end

    function automatic ctrl_t mk(input logic alusrc, input logic [3:0] op, input logic rw,
                                 input logic mr, input logic mw, input logic m2r, input logic br);
        ctrl_t c;
        c.alusrc = alusrc; c.alucontrol = op; c.regwrite = rw; c.memread = mr;
        c.memwrite = mw; c.memtoreg = m2r; c.branch = br;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input ctrl_t c, input logic [REG_AW-1:0] rn, input logic [REG_AW-1:0] rm,
                         input logic [REG_AW-1:0] rd, input logic [N-1:0] rd1,
                         input logic [N-1:0] rd2, input logic [N-1:0] imm);
        id_bus.id_valid = 1'b1; id_bus.id_ctrl = c;
        id_bus.id_rn = rn; id_bus.id_rm = rm; id_bus.id_rd = rd;
        id_bus.id_rd1 = rd1; id_bus.id_rd2 = rd2; id_bus.id_imm = imm;
    endtask

    task automatic no_fwd();
        exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    initial begin
        ctrl_t c;
        flush = 1'b0;
        no_fwd();
        issue(mk(1'b1, ALU_SUB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1), 5'd3, 5'd4, 5'd5,
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});

        // Reset held with live decode input
        tick();
        chk_en = 1'b1;
        tick(); tick();
        #2;
        check("rst_valid", N'(ex_valid), '0);
        check("rst_aluc",  N'(alu_control), '0);
        check("rst_a",     alu_a, '0);
        check("rst_b",     alu_b, '0);
        issue(mk(1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 5'd1, 5'd2, 5'd9, 64'h11, 64'h22, 64'h0);
        reset = 1'b1;
        tick(); #2;
        check("first_op_valid", N'(ex_valid), N'(1));
        check("first_op_a",     alu_a, 64'h11);

        // EX/MEM forward to A
        issue(mk(1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 5'd3, 5'd6, 5'd9, 64'h5, 64'h7, 64'h0);
        tick();
        exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 64'h10;
        #2;
        check("exmem_fwd_a", alu_a, 64'h10);
        check("exmem_fwd_b", alu_b, 64'h7);

        // Priority and zero register
        issue(mk(1'b0, ALU_ORR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 5'd31, 5'd4, 5'd9, 64'h21, 64'h33, 64'h0);
        tick();
        exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 64'hAA;
        memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_result = 64'hBB;
        #2;
        check("prio_b", alu_b, 64'hAA);
        #5;
        exmem_rd = 5'd31; memwb_rd = 5'd31;
        #2;
        check("xzr_a", alu_a, 64'h21);
        check("xzr_b", alu_b, 64'h33);
        #5;
        exmem_regwrite = 1'b0; memwb_rd = 5'd4;
        #2;
        check("memwb_b", alu_b, 64'hBB);
        no_fwd();

        // Load-use: LDUR X2 then ADD X5, X2, X3
        issue(mk(1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), 5'd9, 5'd2, 5'd2, 64'h100, 64'h0, 64'h8);
        tick();
        issue(mk(1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 5'd2, 5'd3, 5'd5, 64'hDEAD, 64'h3, 64'h0);
        #2;
        check("lu_ready", N'(id_bus.id_ready), '0);
        tick(); #2;
        check("lu_bubble_valid", N'(ex_valid), '0);
        check("lu_bubble_rw",    N'(ex_ctrl.regwrite), '0);
        check("lu_ready_back",   N'(id_bus.id_ready), N'(1));
        tick();
        memwb_regwrite = 1'b1; memwb_rd = 5'd2; memwb_result = 64'h77;
        #2;
        check("lu_issue_valid", N'(ex_valid), N'(1));
        check("lu_issue_a",     alu_a, 64'h77);
        no_fwd();

        // STUR with immediate and forwarded store data
        issue(mk(1'b1, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 5'd1, 5'd7, 5'd7, 64'h40, 64'h1, 64'h8);
        tick();
        exmem_regwrite = 1'b1; exmem_rd = 5'd7; exmem_result = 64'h55;
        #2;
        check("stur_b",     alu_b, 64'h8);
        check("stur_store", ex_store_data, 64'h55);
        no_fwd();

        // Flush
        issue(mk(1'b0, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h0);
        flush = 1'b1;
        tick(); #2;
        check("flush_valid", N'(ex_valid), '0);
        check("flush_mw",    N'(ex_ctrl.memwrite), '0);
        check("flush_rw",    N'(ex_ctrl.regwrite), '0);
        flush = 1'b0;

        // Flush during stall: the held instruction issues afterwards
        issue(mk(1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), 5'd9, 5'd2, 5'd2, 64'h100, 64'h0, 64'h8);
        tick();
        issue(mk(1'b0, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 5'd2, 5'd3, 5'd5, 64'h9, 64'h3, 64'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #2;
        check("fs_bubble", N'(ex_valid), '0);
        tick(); #2;
        check("fs_issue_valid", N'(ex_valid), N'(1));
        check("fs_issue_rd",    N'(ex_rd), N'(5));
        check("fs_issue_op",    N'(alu_control), N'(ALU_SUB));

        // Reset during a stall releases it at once
        issue(mk(1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), 5'd9, 5'd2, 5'd2, 64'h100, 64'h0, 64'h8);
        tick();
        issue(mk(1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 5'd2, 5'd3, 5'd5, 64'h9, 64'h3, 64'h0);
        #1;
        check("rs_stalled", N'(id_bus.id_ready), '0);
        reset = 1'b0;
        #1;
        check("rs_ready", N'(id_bus.id_ready), N'(1));
        check("rs_valid", N'(ex_valid), '0);
        tick();
        reset = 1'b1;

        // Random traffic against the model; decode holds while stalled
        for (int i = 0; i < 200; i++) begin
            logic [REG_AW-1:0] regs [4];
            regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd3; regs[3] = 5'd31;
            if (id_bus.id_ready) begin
                c = ctrl_t'($urandom);
                issue(c, regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
                      regs[$urandom_range(0, 3)], {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom});
                id_bus.id_valid = ($urandom_range(0, 4) != 0);
            end
            flush          = ($urandom_range(0, 7) == 0);
            exmem_regwrite = $urandom_range(0, 1) == 1;
            exmem_rd       = regs[$urandom_range(0, 3)];
            exmem_result   = {$urandom, $urandom};
            memwb_regwrite = $urandom_range(0, 1) == 1;
            memwb_rd       = regs[$urandom_range(0, 3)];
            memwb_result   = {$urandom, $urandom};
            tick();
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
